// File: rtl/psram_arb.sv
// psram_arb -- two-client burst arbiter in front of a PSRAM controller.
//
// Arbitrates between a capture writer (8-beat write bursts) and a video
// reader (4-beat read bursts). Each granted burst is driven onto an
// AXI-like downstream port. Round-robin decides between simultaneous
// requests, and a watchdog aborts any burst that runs too long.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   psram_ready                  downstream accepts new bursts
//   wr_req/wr_addr/wr_data       writer request, start address, show-ahead beat
//   wr_pop, wr_ack               writer beat consumed, write burst complete
//   rd_req/rd_addr               reader request, start address
//   rd_valid/rd_data, rd_done    forwarded read beat, read burst complete
//   aw*/w*/bvalid                downstream write address/data/response
//   ar*/rvalid/rdata             downstream read address/data
//   timeout_err                  burst aborted by the watchdog
module psram_arb #(
    parameter int ADDR_W      = 25,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psram_ready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_pop,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [17:0]       rd_data,
    output logic              rd_done,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [15:0]       wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [17:0]       rdata,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        WDAT,
        WRSP,
        AR,
        RDAT
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        beat_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic              last_wr_reg;   // 1: last grant went to the writer

    logic expire;
    logic live;
    logic grant_wr;
    logic grant_rd;

    // Watchdog fires on the last allowed cycle of a burst.
    assign expire = (state_reg != IDLE) && (wdog_reg == WD_W'(TIMEOUT_CYC - 1));

    // Outputs are suppressed while reset is asserted and on the abort cycle,
    // so neither an abandoned nor an expired burst can emit a stray pulse.
    assign live = reset_n && !expire;

    // Round-robin: on a tie the side not granted last wins.
    assign grant_wr = psram_ready && wr_req && (!rd_req || !last_wr_reg);
    assign grant_rd = psram_ready && rd_req && (!wr_req ||  last_wr_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            beat_reg    <= '0;
            wdog_reg    <= '0;
            last_wr_reg <= 1'b0;
        end else if (expire) begin
            // last_wr_reg already names the aborted requester.
            state_reg <= IDLE;
        end else begin
            if (state_reg != IDLE)
                wdog_reg <= wdog_reg + WD_W'(1);
            case (state_reg)
                IDLE: begin
                    if (grant_wr) begin
                        state_reg   <= AW;
                        addr_reg    <= wr_addr;
                        last_wr_reg <= 1'b1;
                        wdog_reg    <= '0;
                    end else if (grant_rd) begin
                        state_reg   <= AR;
                        addr_reg    <= rd_addr;
                        last_wr_reg <= 1'b0;
                        wdog_reg    <= '0;
                    end
                end
                AW: begin
                    if (awready) begin
                        state_reg <= WDAT;
                        beat_reg  <= '0;
                    end
                end
                WDAT: begin
                    if (wready) begin
                        if (beat_reg != 4'd8)
                            beat_reg <= beat_reg + 4'd1;
                        if (beat_reg == 4'd7)
                            state_reg <= WRSP;
                    end
                end
                WRSP: begin
                    if (bvalid)
                        state_reg <= IDLE;
                end
                AR: begin
                    if (arready) begin
                        state_reg <= RDAT;
                        beat_reg  <= '0;
                    end
                end
                RDAT: begin
                    if (rvalid) begin
                        if (beat_reg != 4'd8)
                            beat_reg <= beat_reg + 4'd1;
                        if (beat_reg == 4'd3)
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        awaddr      = addr_reg;
        araddr      = addr_reg;
        awlen       = 8'h08;
        arlen       = 8'h04;
        awvalid     = live && (state_reg == AW);
        wvalid      = live && (state_reg == WDAT);
        wdata       = (live && (state_reg == WDAT)) ? wr_data : 16'h0000;
        wr_pop      = live && (state_reg == WDAT) && wready;
        wr_ack      = live && (state_reg == WRSP) && bvalid;
        arvalid     = live && (state_reg == AR);
        rd_valid    = live && (state_reg == RDAT) && rvalid;
        rd_data     = (live && (state_reg == RDAT) && rvalid) ? rdata : 18'h00000;
        rd_done     = live && (state_reg == RDAT) && rvalid && (beat_reg == 4'd3);
        timeout_err = reset_n && expire;
    end

endmodule

// File: tb/tb_psram_arb.sv
// tb_psram_arb -- directed bench for psram_arb with hand-computed timelines.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. The watchdog is shortened to 16 cycles.
module tb_psram_arb;

    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              psram_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_pop;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [17:0]       rd_data;
    logic              rd_done;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [15:0]       wdata;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;
    logic              rvalid;
    logic [17:0]       rdata;
    logic              timeout_err;

    int err_cnt = 0;
    int chk_cnt = 0;

    psram_arb #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n), .psram_ready(psram_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_pop(wr_pop), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .bvalid(bvalid),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata  = 18'h0;
    endtask

    // Services a granted write with all handshakes high; counts pops to the ack.
    task automatic finish_write(input string tag);
        int pops = 0;
        bit acked = 0;
        for (int i = 0; i < 20 && !acked; i++) begin
            cyc();
            smp();
            if (wr_pop) pops++;
            if (wr_ack) acked = 1;
        end
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check({tag, "_pops"}, 32'(pops), 32'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0]  seq [4];
        logic [17:0] rd_vec [4];
        logic [7:0]  rv_pat;
        int          n;
        int          bi;
        bit          done;

        reset_n = 1'b0; psram_ready = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_data = 16'h0;
        rd_req = 1'b0; rd_addr = '0;
        bus_idle();
        repeat (3) cyc();

        // ---- reset state ----
        smp();
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_awaddr", 32'(awaddr), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_awlen", 32'(awlen), 32'h08);
        check("rst_arlen", 32'(arlen), 32'h04);

        // ---- single write burst at 0x100 ----
        cyc();
        reset_n = 1'b1; wr_req = 1'b1; wr_addr = 25'h0000100;
        awready = 1'b1; wready = 1'b1;
        smp();
        check("w1_idle_awvalid", 32'(awvalid), 0);
        cyc();
        smp();
        check("w1_awvalid", 32'(awvalid), 1);
        check("w1_awaddr", 32'(awaddr), 32'h100);
        for (int b = 0; b < 8; b++) begin
            cyc();
            wr_data = 16'hA000 + 16'(b);
            smp();
            check($sformatf("w1_pop%0d", b), 32'(wr_pop), 1);
            check($sformatf("w1_wdata%0d", b), 32'(wdata), 32'hA000 + 32'(b));
        end
        cyc();
        smp();
        check("w1_wrsp_pop", 32'(wr_pop), 0);
        check("w1_wrsp_noack", 32'(wr_ack), 0);
        cyc();
        bvalid = 1'b1;
        smp();
        check("w1_ack", 32'(wr_ack), 1);
        cyc();
        wr_req = 1'b0; bus_idle();
        smp();
        check("w1_after_ack", 32'(wr_ack), 0);
        check("w1_after_awvalid", 32'(awvalid), 0);
        $display("write burst @0x100 complete");

        // ---- single read burst at 0x1000000, sparse rvalid ----
        cyc();
        rd_req = 1'b1; rd_addr = 25'h1000000;
        smp();
        check("r1_idle_arvalid", 32'(arvalid), 0);
        cyc();
        smp();
        check("r1_arvalid", 32'(arvalid), 1);
        check("r1_araddr", 32'(araddr), 32'h1000000);
        cyc();
        arready = 1'b1;
        smp();
        check("r1_arvalid_hold", 32'(arvalid), 1);
        rd_vec[0] = 18'h3FFFF; rd_vec[1] = 18'h15555;
        rd_vec[2] = 18'h2AAAA; rd_vec[3] = 18'h00001;
        rv_pat = 8'b1010_0101;  // rvalid on steps 0, 2, 5, 7
        bi = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            arready = 1'b0;
            rvalid  = rv_pat[i];
            rdata   = rv_pat[i] ? rd_vec[bi] : 18'h12345;
            smp();
            check($sformatf("r1_valid%0d", i), 32'(rd_valid), 32'(rv_pat[i]));
            check($sformatf("r1_done%0d", i), 32'(rd_done), (i == 7) ? 32'd1 : 32'd0);
            if (rv_pat[i]) begin
                check($sformatf("r1_data%0d", bi), 32'(rd_data), 32'(rd_vec[bi]));
                bi++;
            end
        end
        cyc();
        rd_req = 1'b0; bus_idle();
        rvalid = 1'b1; rdata = 18'h3C3C3;
        smp();
        check("r1_after_valid", 32'(rd_valid), 0);
        check("r1_after_arvalid", 32'(arvalid), 0);
        $display("read burst @0x1000000 complete");

        // ---- both requesting: W,R,W,R alternation ----
        cyc();
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 25'h0000200; rd_addr = 25'h0000300;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        arready = 1'b1; rvalid = 1'b1; rdata = 18'h00ABC;
        n = 0; done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            smp();
            if (awvalid && n < 4) begin seq[n] = "W"; n++; end
            if (arvalid && n < 4) begin seq[n] = "R"; n++; end
            if (n >= 4 && rd_done) done = 1;
            cyc();
            if (n >= 4) wr_req = 1'b0;  // withdrawn before being granted again
        end
        check("rr_grants", 32'(n), 4);
        check("rr_finished", 32'(done), 1);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_seq%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'("W") : 32'("R"));
        rd_req = 1'b0;
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            smp();
            check($sformatf("cancel_awvalid%0d", i), 32'(awvalid), 0);
            check($sformatf("cancel_arvalid%0d", i), 32'(arvalid), 0);
            cyc();
        end
        $display("round-robin sequence complete");

        // ---- psram_ready gating, then drop mid-burst ----
        psram_ready = 1'b0; wr_req = 1'b1; rd_req = 1'b1; wr_addr = 25'h1ABCDEF;
        for (int i = 0; i < 3; i++) begin
            smp();
            check($sformatf("nordy_awvalid%0d", i), 32'(awvalid), 0);
            check($sformatf("nordy_arvalid%0d", i), 32'(arvalid), 0);
            cyc();
        end
        psram_ready = 1'b1;
        smp();
        check("rdy_rise_awvalid", 32'(awvalid), 0);
        cyc();
        psram_ready = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        smp();
        check("rdy_grant_awvalid", 32'(awvalid), 1);
        check("rdy_grant_arvalid", 32'(arvalid), 0);
        check("rdy_grant_awaddr", 32'(awaddr), 32'h1ABCDEF);
        finish_write("rdy_drop");
        cyc();
        wr_req = 1'b0; rd_req = 1'b0; psram_ready = 1'b1; bus_idle();
        smp();
        check("rdy_after_arvalid", 32'(arvalid), 0);
        $display("write burst @0x1ABCDEF complete with psram_ready low");

        // ---- read watchdog: only two beats ----
        cyc();
        rd_req = 1'b1; rd_addr = 25'h0000055;
        smp();
        check("wd_idle_arvalid", 32'(arvalid), 0);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            arready = (k == 1);
            rvalid  = (k == 3 || k == 5);
            rdata   = 18'h00F00 + 18'(k);
            smp();
            check($sformatf("wd_timeout%0d", k), 32'(timeout_err), (k == 16) ? 32'd1 : 32'd0);
            check($sformatf("wd_done%0d", k), 32'(rd_done), 0);
            if (k == 3 || k == 5)
                check($sformatf("wd_valid%0d", k), 32'(rd_valid), 1);
        end
        cyc();
        rd_req = 1'b0; bus_idle();
        rvalid = 1'b1; rdata = 18'h1FFFF;
        smp();
        check("wd_stray_valid", 32'(rd_valid), 0);
        check("wd_stray_done", 32'(rd_done), 0);
        check("wd_after_timeout", 32'(timeout_err), 0);
        cyc();
        smp();
        check("wd_idle_arvalid2", 32'(arvalid), 0);
        check("wd_idle_valid2", 32'(rd_valid), 0);
        bus_idle();
        $display("read burst @0x55 aborted by watchdog");

        // ---- reset during WDAT beat 3 ----
        cyc();
        wr_req = 1'b1; wr_addr = 25'h0000222; awready = 1'b1; wready = 1'b1;
        smp();
        cyc();
        smp();
        check("rst_mid_awvalid", 32'(awvalid), 1);
        for (int b = 0; b < 3; b++) begin
            cyc();
            smp();
            check($sformatf("rst_mid_pop%0d", b), 32'(wr_pop), 1);
        end
        cyc();
        reset_n = 1'b0;  // beat 3 is on the bus this cycle
        smp();
        cyc();
        reset_n = 1'b1;
        smp();
        check("rst_mid_awvalid0", 32'(awvalid), 0);
        check("rst_mid_wvalid0", 32'(wvalid), 0);
        check("rst_mid_pop0", 32'(wr_pop), 0);
        check("rst_mid_ack0", 32'(wr_ack), 0);
        check("rst_mid_arvalid0", 32'(arvalid), 0);
        check("rst_mid_rdvalid0", 32'(rd_valid), 0);
        check("rst_mid_done0", 32'(rd_done), 0);
        check("rst_mid_timeout0", 32'(timeout_err), 0);
        check("rst_mid_awaddr0", 32'(awaddr), 0);
        cyc();
        bvalid = 1'b1;
        smp();
        check("rst_restart_awvalid", 32'(awvalid), 1);
        check("rst_restart_awaddr", 32'(awaddr), 32'h222);
        finish_write("rst_restart");
        cyc();
        wr_req = 1'b0; bus_idle();
        $display("write burst @0x222 restarted after reset");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/psram_arb.md
PSRAM_ARB -- requirements
Module: psram_arb

Interface
REQ-001 Parameter: ADDR_W, default 25, PSRAM word-address width.
REQ-002 Parameter: TIMEOUT_CYC, default 1024, maximum cycles allowed per granted transaction.
REQ-003 clk  in  1  system clock (48 MHz domain); the one clock; all logic on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 psram_ready  in  1  high when the downstream controller accepts requests.
REQ-006 wr_req, wr_addr  in  1, ADDR_W  capture-writer request and burst start address.
REQ-007 wr_data  in  16  write beat, show-ahead (valid whenever wr_req is high).
REQ-008 wr_pop  out  1  write beat consumed this cycle.
REQ-009 wr_ack  out  1  one-cycle pulse: write burst complete.
REQ-010 rd_req, rd_addr  in  1, ADDR_W  video-reader request and burst start address.
REQ-011 rd_valid, rd_data  out  1, 18  forwarded read beat.
REQ-012 rd_done  out  1  one-cycle pulse: read burst complete.
REQ-013 awaddr, awlen, awvalid, awready  out/out/out/in  ADDR_W, 8, 1, 1  downstream write-address channel; awlen fixed 8'h08.
REQ-014 wdata, wvalid, wready  out/out/in  16, 1, 1  downstream write-data channel.
REQ-015 bvalid  in  1  downstream write response; bready tied high by the parent.
REQ-016 araddr, arlen, arvalid, arready  out/out/out/in  ADDR_W, 8, 1, 1  downstream read-address channel; arlen fixed 8'h04.
REQ-017 rvalid, rdata  in  1, 18  downstream read data; rready tied high by the parent.
REQ-018 timeout_err  out  1  one-cycle pulse: transaction aborted by watchdog.

Function
REQ-019 FSM states: IDLE, AW, WDAT, WRSP, AR, RDAT.
REQ-020 IDLE: with psram_ready low, no grant.
REQ-021 IDLE, psram_ready high, a single requester high: grant it, register its address, go to AW (write) or AR (read) on the next cycle.
REQ-022 Both requesting: grant the one not granted last (round-robin); the last-grant flag resets to "read", so write wins the first tie.
REQ-023 AW: awvalid=1, awaddr=registered address; on awready go to WDAT with beat count 0.
REQ-024 WDAT: wvalid=1; wdata=wr_data; wr_pop=wready; each wready increments beat count; the 8th beat goes to WRSP.
REQ-025 WRSP: on bvalid pulse wr_ack, then IDLE.
REQ-026 AR: arvalid=1, araddr=registered address; on arready go to RDAT with beat count 0.
REQ-027 RDAT: rd_valid=rvalid, rd_data=rdata; the 4th beat pulses rd_done on the same cycle, then IDLE.
REQ-028 Minimum gap: one IDLE cycle between consecutive grants.
REQ-029 rvalid outside RDAT, and bvalid outside WRSP, are ignored: not forwarded, no state change.
REQ-030 Requesters hold req until ack/done.
REQ-031 A request dropped before its grant is cancelled.
REQ-032 After a grant, the burst completes regardless of req.
REQ-033 psram_ready falling mid-burst does not abort the burst.
REQ-034 Watchdog: cycle counter cleared on every grant, increments in every non-IDLE state.
REQ-035 Watchdog expiry (counter reaches TIMEOUT_CYC-1 while non-IDLE): pulse timeout_err, go to IDLE, drop valids, no ack/done; the granted requester becomes last-grant.
REQ-036 Beat counter 4 bits, saturates at 8 and never wraps; watchdog counter width clog2(TIMEOUT_CYC)+1.
REQ-037 Valid outputs are combinational from state; addresses come from registers.

Reset
REQ-038 reset_n low at a clock edge: state IDLE; awvalid, wvalid, arvalid, wr_pop, wr_ack, rd_valid, rd_done, timeout_err = 0; addresses, counters = 0; last-grant = read.
REQ-039 Reset mid-burst abandons the burst immediately, with no ack/done/err pulse.

Verification
REQ-040 wr_req with addr 0x0000100, awready immediate, wready always high -> awaddr=0x0000100, exactly 8 wr_pop cycles, a single wr_ack on the bvalid cycle.
REQ-041 rd_req with addr 0x1000000, rvalid on 4 non-consecutive cycles with rdata 0x3FFFF..0x00001 -> 4 rd_valid beats with matching data, rd_done on the 4th.
REQ-042 wr_req and rd_req held continuously after reset -> grants alternate W,R,W,R; no requester waits more than one burst.
REQ-043 psram_ready low with requests pending -> no awvalid/arvalid; psram_ready rising -> grant on the next cycle.
REQ-044 Granted read, only 2 rvalid beats, TIMEOUT_CYC=16 -> timeout_err at 16 cycles after grant, no rd_done, FSM IDLE; a stray rvalid afterwards is ignored.
REQ-045 reset_n low during WDAT beat 3 -> all outputs 0 on the next cycle; the following wr_req restarts at beat 0.
